ysyx_23060042_exec_ctrl: RTL and testbench
==========================================

YSYX_23060042_EXEC_CTRL -- requirements
Module: ysyx_23060042_exec_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max cycles in MEM awaiting mem_ready before error.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ifu_rvalid  input  1  fetched instruction valid.
REQ-005 SHALL have port dec_regen  input  1  decoded register-write enable.
REQ-006 SHALL have port dec_pcjen  input  1  decoded PC jump/redirect enable.
REQ-007 SHALL have port dec_mwen  input  2  decoded memory-write size code (00 = no write).
REQ-008 SHALL have port dec_mren  input  2  decoded memory-read size code (00 = no read).
REQ-009 SHALL have port dec_brken  input  1  decoded break/halt instruction.
REQ-010 SHALL have port mem_ready  input  1  LSU transfer complete.
REQ-011 SHALL have port ifu_req  output  1  fetch request.
REQ-012 SHALL have port ir_we  output  1  instruction-register load strobe.
REQ-013 SHALL have port mem_req, mem_wr  output  1 each  LSU request; write when 1.
REQ-014 SHALL have port mem_size  output  2  LSU size code.
REQ-015 SHALL have port rf_we, pc_we, pc_jump  output  1 each  writeback strobes; pc_jump selects redirect target.
REQ-016 SHALL have port halt, mem_err  output  1 each  sticky status.
REQ-017 SHALL have port state  output  3  current FSM state encoding.
REQ-018 SHALL have port cycle_cnt, instret_cnt  output  32 each  performance counters.

Function
REQ-019 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT next cycle.
REQ-020 FETCH: ifu_req=1 held until ifu_rvalid; on ifu_rvalid, ir_we=1 that cycle and next state DECODE.
REQ-021 DECODE (1 cycle): SHALL register dec_regen/pcjen/mwen/mren into internal copies; dec_brken=1 -> HALT, halt=1; else EXEC.
REQ-022 Decode inputs SHALL be sampled only in DECODE; later states use the registered copies.
REQ-023 EXEC (1 cycle): registered mwen!=0 or mren!=0 -> MEM, else WB.
REQ-024 MEM: mem_req=1, mem_wr=(mwen!=0), mem_size=mwen if write else mren; held stable until mem_ready; on mem_ready -> WB.
REQ-025 Write takes priority if both mwen and mren nonzero.
REQ-026 MEM timeout counter SHALL clear on MEM entry, increment per MEM cycle; reaching MEM_TIMEOUT without mem_ready -> HALT, mem_err=1, halt=1.
REQ-027 mem_ready in the same cycle the timeout would fire SHALL win (-> WB, no error).
REQ-028 WB (1 cycle): pc_we=1, pc_jump=registered pcjen, rf_we=registered regen, instret_cnt+1, next FETCH.
REQ-029 Minimum latency per non-memory instruction: 4 cycles after ifu_rvalid (FETCH-exit to FETCH).
REQ-030 ifu_rvalid outside FETCH and mem_ready outside MEM SHALL be ignored.
REQ-031 cycle_cnt SHALL increment every cycle except in HALT; both counters wrap 0xFFFFFFFF -> 0.
REQ-032 HALT SHALL be absorbing; all strobes/requests 0; only reset exits.
REQ-033 All outputs except counters, halt, mem_err, state SHALL be registered-state decodes with no combinational path from inputs except ir_we (ifu_rvalid).

Reset
REQ-034 rst_n=0 SHALL immediately force state=FETCH, all strobes, requests, halt, mem_err, timeout counter, registered decode copies and both counters to 0, including mid-MEM.
REQ-035 After rst_n deasserts, ifu_req SHALL assert on the first clk edge's following cycle.

Verification
REQ-036 ADD-like (regen=1, others 0), ifu_rvalid at cycle 2 -> ir_we cycle 2, rf_we=pc_we=1 cycle 5, instret_cnt=1.
REQ-037 Store (mwen=10), mem_ready after 3 MEM cycles -> mem_req=1, mem_wr=1, mem_size=10 for 3 cycles, then WB with rf_we=0.
REQ-038 Load (mren=01), mem_ready never -> after 255 MEM cycles mem_err=1, halt=1, state=5, cycle_cnt frozen.
REQ-039 dec_brken=1 at DECODE -> halt=1 next cycle, no pc_we/rf_we, stays HALT 100 cycles; rst_n pulse -> FETCH, counters 0.
REQ-040 rst_n asserted mid-MEM with mem_req=1 -> mem_req=0 same cycle asynchronously, state=0; mem_ready coincident with timeout -> WB, mem_err=0.

Source files
------------

// File: rtl/ysyx_23060042_exec_ctrl_if.sv
// Handshake bundle between the execution controller and the fetch, decode,
// LSU and writeback blocks around it.
interface ysyx_23060042_exec_ctrl_if;
   logic        ifu_rvalid;
   logic        dec_regen;
   logic        dec_pcjen;
   logic [1:0]  dec_mwen;
   logic [1:0]  dec_mren;
   logic        dec_brken;
   logic        mem_ready;
   logic        ifu_req;
   logic        ir_we;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic        rf_we;
   logic        pc_we;
   logic        pc_jump;
   logic        halt;
   logic        mem_err;
   logic [2:0]  state;
   logic [31:0] cycle_cnt;
   logic [31:0] instret_cnt;

   modport slave (
      input  ifu_rvalid, dec_regen, dec_pcjen, dec_mwen, dec_mren, dec_brken, mem_ready,
      output ifu_req, ir_we, mem_req, mem_wr, mem_size, rf_we, pc_we, pc_jump,
             halt, mem_err, state, cycle_cnt, instret_cnt
   );

   modport master (
      output ifu_rvalid, dec_regen, dec_pcjen, dec_mwen, dec_mren, dec_brken, mem_ready,
      input  ifu_req, ir_we, mem_req, mem_wr, mem_size, rf_we, pc_we, pc_jump,
             halt, mem_err, state, cycle_cnt, instret_cnt
   );
endinterface

// File: rtl/ysyx_23060042_exec_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional LSU
// access with timeout, writeback; plus cycle and retired-instruction counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | request instruction, load IR on ifu_rvalid
// DECODE | capture decoded controls, divert to HALT on break
// EXEC   | choose MEM or WB from captured load/store codes
// MEM    | hold LSU request until mem_ready or timeout
// WB     | PC/RF write strobes, retire instruction
// HALT   | absorbing stop state, left only through reset
module ysyx_23060042_exec_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input logic clk,
   input logic rst_n,
   ysyx_23060042_exec_ctrl_if.slave bus
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t      state_q;
   logic        ifu_req_q;
   logic        mem_req_q;
   logic        mem_wr_q;
   logic [1:0]  mem_size_q;
   logic        rf_we_q;
   logic        pc_we_q;
   logic        pc_jump_q;
   logic        halt_q;
   logic        mem_err_q;
   logic        regen_q;
   logic        pcjen_q;
   logic [1:0]  mwen_q;
   logic [1:0]  mren_q;
   logic [TW-1:0] tmo_q;
   logic [31:0] cycle_cnt_q;
   logic [31:0] instret_cnt_q;

   // Strobes are registered for the state being entered, so they default
   // low every cycle and each transition re-asserts what its target needs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_FETCH;
         ifu_req_q     <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_size_q    <= 2'b00;
         rf_we_q       <= 1'b0;
         pc_we_q       <= 1'b0;
         pc_jump_q     <= 1'b0;
         halt_q        <= 1'b0;
         mem_err_q     <= 1'b0;
         regen_q       <= 1'b0;
         pcjen_q       <= 1'b0;
         mwen_q        <= 2'b00;
         mren_q        <= 2'b00;
         tmo_q         <= '0;
         cycle_cnt_q   <= 32'd0;
         instret_cnt_q <= 32'd0;
      end else begin
         ifu_req_q  <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_size_q <= 2'b00;
         rf_we_q    <= 1'b0;
         pc_we_q    <= 1'b0;
         pc_jump_q  <= 1'b0;

         if (state_q != S_HALT) cycle_cnt_q <= cycle_cnt_q + 32'd1;

         case (state_q)
            S_FETCH: begin
               // ifu_req_q doubles as the "out of reset" qualifier for ifu_rvalid
               if (ifu_req_q && bus.ifu_rvalid) state_q   <= S_DECODE;
               else                             ifu_req_q <= 1'b1;
            end
            S_DECODE: begin
               regen_q <= bus.dec_regen;
               pcjen_q <= bus.dec_pcjen;
               mwen_q  <= bus.dec_mwen;
               mren_q  <= bus.dec_mren;
               if (bus.dec_brken) begin
                  state_q <= S_HALT;
                  halt_q  <= 1'b1;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if ((mwen_q != 2'b00) || (mren_q != 2'b00)) begin
                  state_q    <= S_MEM;
                  tmo_q      <= '0;
                  mem_req_q  <= 1'b1;
                  mem_wr_q   <= (mwen_q != 2'b00);
                  mem_size_q <= (mwen_q != 2'b00) ? mwen_q : mren_q;
               end else begin
                  state_q   <= S_WB;
                  pc_we_q   <= 1'b1;
                  rf_we_q   <= regen_q;
                  pc_jump_q <= pcjen_q;
               end
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  state_q   <= S_WB;
                  pc_we_q   <= 1'b1;
                  rf_we_q   <= regen_q;
                  pc_jump_q <= pcjen_q;
               end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
                  state_q   <= S_HALT;
                  halt_q    <= 1'b1;
                  mem_err_q <= 1'b1;
               end else begin
                  tmo_q      <= tmo_q + TW'(1);
                  mem_req_q  <= 1'b1;
                  mem_wr_q   <= mem_wr_q;
                  mem_size_q <= mem_size_q;
               end
            end
            S_WB: begin
               state_q       <= S_FETCH;
               ifu_req_q     <= 1'b1;
               instret_cnt_q <= instret_cnt_q + 32'd1;
            end
            S_HALT: state_q <= S_HALT;
            default: begin
               state_q <= S_HALT;
               halt_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ifu_req     = ifu_req_q;
   assign bus.ir_we       = (state_q == S_FETCH) && ifu_req_q && bus.ifu_rvalid;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_wr      = mem_wr_q;
   assign bus.mem_size    = mem_size_q;
   assign bus.rf_we       = rf_we_q;
   assign bus.pc_we       = pc_we_q;
   assign bus.pc_jump     = pc_jump_q;
   assign bus.halt        = halt_q;
   assign bus.mem_err     = mem_err_q;
   assign bus.state       = state_q;
   assign bus.cycle_cnt   = cycle_cnt_q;
   assign bus.instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_ysyx_23060042_exec_ctrl.sv
// Directed bench for the execution controller: ALU, jump, store, load with
// late ready, load timeout, break, and asynchronous reset mid-MEM.
module tb_ysyx_23060042_exec_ctrl;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   ncyc;
   bit   running;

   ysyx_23060042_exec_ctrl_if bus ();

   ysyx_23060042_exec_ctrl #(.MEM_TIMEOUT(255)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (running) ncyc++;
   endtask

   // Enters in a FETCH cycle, leaves in the cycle after DECODE.
   task automatic fetch_decode(input logic regen, input logic pcjen, input logic [1:0] mwen,
                               input logic [1:0] mren, input logic brken);
      chk("fd_state_fetch", 32'(bus.state), 32'd0);
      chk("fd_ifu_req", 32'(bus.ifu_req), 32'd1);
      chk("fd_cycle_cnt", bus.cycle_cnt, 32'(ncyc));
      bus.ifu_rvalid = 1'b1;
      #1;
      chk("fd_ir_we", 32'(bus.ir_we), 32'd1);
      tick();
      bus.ifu_rvalid = 1'b0;
      bus.dec_regen  = regen;
      bus.dec_pcjen  = pcjen;
      bus.dec_mwen   = mwen;
      bus.dec_mren   = mren;
      bus.dec_brken  = brken;
      chk("fd_state_decode", 32'(bus.state), 32'd1);
      chk("fd_ifu_req_off", 32'(bus.ifu_req), 32'd0);
      if (brken) running = 1'b0;
      @(posedge clk);
      #1;
      ncyc++;
      bus.dec_regen = 1'b0;
      bus.dec_pcjen = 1'b0;
      bus.dec_mwen  = 2'b00;
      bus.dec_mren  = 2'b00;
      bus.dec_brken = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_halt", 32'(bus.halt), 32'd0);
      chk("rst_mem_err", 32'(bus.mem_err), 32'd0);
      chk("rst_cycle_cnt", bus.cycle_cnt, 32'd0);
      chk("rst_instret", bus.instret_cnt, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rst_ifu_req_idle", 32'(bus.ifu_req), 32'd0);
      ncyc    = 0;
      running = 1'b1;
      tick();
      chk("rst_ifu_req_first", 32'(bus.ifu_req), 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      ncyc  = 0;
      running = 1'b0;
      rst_n = 1'b0;
      bus.ifu_rvalid = 1'b0;
      bus.dec_regen  = 1'b0;
      bus.dec_pcjen  = 1'b0;
      bus.dec_mwen   = 2'b00;
      bus.dec_mren   = 2'b00;
      bus.dec_brken  = 1'b0;
      bus.mem_ready  = 1'b0;
      #1;
      chk("init_state", 32'(bus.state), 32'd0);
      chk("init_ifu_req", 32'(bus.ifu_req), 32'd0);
      chk("init_cycle_cnt", bus.cycle_cnt, 32'd0);
      chk("init_halt", 32'(bus.halt), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #7;
      rst_n = 1'b1;
      #1;
      chk("rel_ifu_req_idle", 32'(bus.ifu_req), 32'd0);
      running = 1'b1;
      tick();
      chk("rel_ifu_req", 32'(bus.ifu_req), 32'd1);
      chk("rel_cycle_cnt", bus.cycle_cnt, 32'd1);

      // ADD-like: idle fetch cycle, then regen only
      tick();
      chk("add_wait_state", 32'(bus.state), 32'd0);
      fetch_decode(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
      bus.ifu_rvalid = 1'b1;
      bus.mem_ready  = 1'b1;
      #1;
      chk("add_exec_state", 32'(bus.state), 32'd2);
      chk("add_ir_we_ignored", 32'(bus.ir_we), 32'd0);
      tick();
      bus.ifu_rvalid = 1'b0;
      bus.mem_ready  = 1'b0;
      chk("add_wb_state", 32'(bus.state), 32'd4);
      chk("add_pc_we", 32'(bus.pc_we), 32'd1);
      chk("add_rf_we", 32'(bus.rf_we), 32'd1);
      chk("add_pc_jump", 32'(bus.pc_jump), 32'd0);
      chk("add_mem_req", 32'(bus.mem_req), 32'd0);
      tick();
      chk("add_back_fetch", 32'(bus.state), 32'd0);
      chk("add_instret", bus.instret_cnt, 32'd1);

      // jump, no register write
      fetch_decode(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      tick();
      chk("jmp_pc_jump", 32'(bus.pc_jump), 32'd1);
      chk("jmp_rf_we", 32'(bus.rf_we), 32'd0);
      chk("jmp_pc_we", 32'(bus.pc_we), 32'd1);
      tick();
      chk("jmp_instret", bus.instret_cnt, 32'd2);

      // store with a read code too: write wins; ready in third MEM cycle
      fetch_decode(1'b0, 1'b0, 2'b10, 2'b01, 1'b0);
      tick();
      for (int i = 1; i <= 3; i++) begin
         chk("st_mem_req", 32'(bus.mem_req), 32'd1);
         chk("st_mem_wr", 32'(bus.mem_wr), 32'd1);
         chk("st_mem_size", 32'(bus.mem_size), 32'd2);
         if (i == 3) bus.mem_ready = 1'b1;
         else tick();
      end
      tick();
      bus.mem_ready = 1'b0;
      chk("st_wb_state", 32'(bus.state), 32'd4);
      chk("st_rf_we", 32'(bus.rf_we), 32'd0);
      chk("st_pc_we", 32'(bus.pc_we), 32'd1);
      chk("st_mem_req_off", 32'(bus.mem_req), 32'd0);
      tick();
      chk("st_instret", bus.instret_cnt, 32'd3);

      // load whose ready coincides with the last allowed MEM cycle
      fetch_decode(1'b1, 1'b0, 2'b00, 2'b01, 1'b0);
      tick();
      repeat (254) tick();
      chk("ld_last_state", 32'(bus.state), 32'd3);
      chk("ld_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("ld_mem_size", 32'(bus.mem_size), 32'd1);
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      chk("ld_race_state", 32'(bus.state), 32'd4);
      chk("ld_race_mem_err", 32'(bus.mem_err), 32'd0);
      chk("ld_race_rf_we", 32'(bus.rf_we), 32'd1);
      tick();
      chk("ld_instret", bus.instret_cnt, 32'd4);

      // load timeout
      fetch_decode(1'b0, 1'b0, 2'b00, 2'b01, 1'b0);
      tick();
      repeat (254) tick();
      chk("to_last_state", 32'(bus.state), 32'd3);
      chk("to_no_err_yet", 32'(bus.mem_err), 32'd0);
      tick();
      running = 1'b0;
      chk("to_state", 32'(bus.state), 32'd5);
      chk("to_mem_err", 32'(bus.mem_err), 32'd1);
      chk("to_halt", 32'(bus.halt), 32'd1);
      chk("to_mem_req", 32'(bus.mem_req), 32'd0);
      repeat (20) tick();
      chk("to_cycle_frozen", bus.cycle_cnt, 32'(ncyc));
      chk("to_instret", bus.instret_cnt, 32'd4);

      // break: halt and stay halted
      do_reset();
      fetch_decode(1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
      chk("brk_state", 32'(bus.state), 32'd5);
      chk("brk_halt", 32'(bus.halt), 32'd1);
      chk("brk_pc_we", 32'(bus.pc_we), 32'd0);
      chk("brk_rf_we", 32'(bus.rf_we), 32'd0);
      bus.ifu_rvalid = 1'b1;
      repeat (100) tick();
      chk("brk_ir_we", 32'(bus.ir_we), 32'd0);
      bus.ifu_rvalid = 1'b0;
      chk("brk_stay_state", 32'(bus.state), 32'd5);
      chk("brk_ifu_req", 32'(bus.ifu_req), 32'd0);
      chk("brk_cycle_frozen", bus.cycle_cnt, 32'(ncyc));

      // asynchronous reset in the middle of MEM
      do_reset();
      fetch_decode(1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
      tick();
      tick();
      chk("mr_mem_req", 32'(bus.mem_req), 32'd1);
      chk("mr_state", 32'(bus.state), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_mem_req_async", 32'(bus.mem_req), 32'd0);
      chk("mr_state_async", 32'(bus.state), 32'd0);
      chk("mr_cycle_cnt", bus.cycle_cnt, 32'd0);
      #5;
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
